// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer that time-shares one external N-bit adder among NREQ requesters.
// Optional ADDER_SHARE_EXACT_CHECK_EN adds rsp_err: the sampled total is compared against an exact a+b.
module adder_share_arbiter #(
  parameter int N      = 8,
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [N:0]        rsp_sum,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  input  logic [N:0]        add_total
`ifdef ADDER_SHARE_EXACT_CHECK_EN
  ,
  output logic              rsp_err
`endif
);

  // Handshakes: a request transfers on req_valid[i] & req_ready[i]; a response
  // transfers on rsp_valid & rsp_ready, and the response is held stable until then.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]      id_q, id_d;
  logic [N:0]      sum_q, sum_d;
  logic            vld_q, vld_d;
  logic [PW-1:0]   grant_idx;
  logic            grant_found;
  logic [N-1:0]    a_slice [NREQ];
  logic [N-1:0]    b_slice [NREQ];

`ifdef ADDER_SHARE_EXACT_CHECK_EN
  logic            err_q, err_d;
  logic [N:0]      exact_sum;
  assign exact_sum = {1'b0, a_q} + {1'b0, b_q};
  assign rsp_err   = err_q;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_slice[i] = req_a[i*N +: N];
    assign b_slice[i] = req_b[i*N +: N];
  end

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    sum_d     = sum_q;
    vld_d     = vld_q;
    req_ready = '0;
`ifdef ADDER_SHARE_EXACT_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = rst_n;
          a_d     = a_slice[grant_idx];
          b_d     = b_slice[grant_idx];
          id_d    = 3'(grant_idx);
          cnt_d   = CW'(SETTLE - 1);
          ptr_d   = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          sum_d   = add_total;
          vld_d   = 1'b1;
`ifdef ADDER_SHARE_EXACT_CHECK_EN
          err_d   = (exact_sum != add_total);
`endif
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
`ifdef ADDER_SHARE_EXACT_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
`ifdef ADDER_SHARE_EXACT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
`ifdef ADDER_SHARE_EXACT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one external n-bit adder (ripple-carry or approximate variant, ports A/B/total) among NREQ requesters.
- Captures one requester's operand pair, drives the adder, waits a programmable settle time for the carry chain, then returns the registered sum tagged with the requester ID.
- Sits between operand producers and the shared adder instance in the approximate-adder evaluation datapath.

Parameters:
- N, 8, operand width; matches the shared adder's n.
- NREQ, 4, number of requesters, 2..8.
- SETTLE, 2, clock cycles the adder output is allowed to settle before sampling, 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request.
- req_ready  output  NREQ  per-requester accept; one-hot, at most one bit high.
- req_a  input  NREQ*N  operand A, slice i = [i*N +: N].
- req_b  input  NREQ*N  operand B, same packing.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  3  index of the requester that owns the result.
- rsp_sum  output  N+1  sampled adder total.
- add_a  output  N  to the shared adder A.
- add_b  output  N  to the shared adder B.
- add_total  input  N+1  from the shared adder total.

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, add_a=0, add_b=0, priority pointer=0, settle counter=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - If any req_valid is high, grant the first requester at or after the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle; a transfer occurs on req_valid[g] & req_ready[g].
  - On the clock edge: latch req_a/req_b slice g into the operand registers, latch g into rsp_id, counter=SETTLE-1, pointer=(g+1) mod NREQ, go to SETTLE.
  - No request: stay in IDLE; add_a/add_b hold their last latched values and are not forced to zero.
- SETTLE:
  - add_a/add_b are driven from the operand registers, stable for the whole state.
  - Counter decrements each cycle. When the counter is 0, rsp_sum<=add_total, rsp_valid<=1, go to RESP.
  - Latency from grant edge to rsp_valid: SETTLE cycles.
- RESP:
  - rsp_valid, rsp_id and rsp_sum are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
  - No new grant in the same cycle; minimum spacing between grants is SETTLE+2 cycles.
- req_ready is 0 in SETTLE and RESP. Requesters must hold req_valid and operands until accepted.
- Arbitration and fairness:
  - A requester that drops req_valid before grant loses nothing.
  - Pointer wrap: grant to NREQ-1 sets pointer=0.
  - With all requesters continuously valid, grants follow 0,1,2,…,NREQ-1,0.
- Width rules:
  - rsp_sum is N+1 bits and carries the adder's carry-out; no truncation.
  - rsp_id uses the low $clog2(NREQ) bits; upper bits are 0.
- Reset mid-operation: the in-flight transaction is discarded and no response is produced after reset. The pointer returns to 0.

Optional Feature:
- Macro: ADDER_SHARE_EXACT_CHECK_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0).
  - At sampling, an internal exact sum a+b (N+1 bits) is compared with add_total; rsp_err=1 on mismatch.
  - rsp_err is held and released together with rsp_valid.
  - Used to flag approximate-adder errors per transaction.
- Undefined: no rsp_err port and no exact adder logic; behaviour is otherwise identical.

Test Plan:
- Reset then single request: req_valid=0001, a0=0x30, b0=0x05, SETTLE=2, exact adder → rsp_valid 2 cycles after grant, rsp_id=0, rsp_sum=0x035.
- All four valid continuously, rsp_ready=1, operands a_i=0x40+i, b_i=0x70 → grant order 0,1,2,3,0; sums 0x0B0,0x0B1,0x0B2,0x0B3.
- Carry-out: a=0xFF, b=0x01 → rsp_sum=0x100.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1111 → rsp_valid/rsp_id/rsp_sum stable, req_ready=0000 throughout; one cycle after the accept, the next grant goes to the pointer's requester.
- Reset mid-SETTLE: assert rst_n=0 asynchronously → all outputs 0 immediately, no response after release; the next request from requester 2 is granted as the first request at or after pointer 0.
- With ADDER_SHARE_EXACT_CHECK_EN: adder model returns total=0x0B6 for a=0x47, b=0x70 → rsp_err=1; exact 0x0B7 → rsp_err=0.
